// File: rtl/mac_requant.sv
// Requantizing output stage for the MAC unit: captures the packed accumulator,
// splits it into 1/2/4 signed lanes, round-shifts, clips and saturates each lane, then streams the lanes out.
//
// state | meaning
// IDLE  | waiting for a capture; acc_ready high
// EMIT  | streaming lanes of the captured accumulator
module mac_requant #(
    parameter int OUT_W    = 8,
    parameter int SATCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_valid,
    output logic                acc_ready,
    input  logic [55:0]         acc_result,
    input  logic [1:0]          prec,
    input  logic [5:0]          shamt,
    input  logic                relu_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [1:0]          out_lane,
    output logic                out_last,
    output logic                prec_err,
    output logic [SATCNT_W-1:0] sat_count
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic signed [56:0] SAT_MAX = (57'sd1 <<< (OUT_W - 1)) - 57'sd1;
    localparam logic signed [56:0] SAT_MIN = -(57'sd1 <<< (OUT_W - 1));

    state_t state;
    state_t state_nxt;

    logic [55:0] acc_q;
    logic [1:0]  prec_q;
    logic [5:0]  shamt_q;
    logic        relu_q;
    logic [1:0]  lane_q;
    logic        out_sat;

    logic        capture;
    logic        accept;
    logic        load;
    logic [1:0]  load_lane;
    logic [1:0]  last_idx;

    logic signed [56:0] lane_val;
    logic signed [56:0] rnd;
    logic signed [56:0] sum;
    logic signed [56:0] y_shift;
    logic signed [56:0] y_clip;
    logic [OUT_W-1:0]   beat_data;
    logic               beat_sat;
    logic               beat_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (acc_valid && prec != 2'b11) state_nxt = EMIT;
            EMIT: if (accept && out_last)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        acc_ready = (state == IDLE);
        capture   = acc_valid && (state == IDLE);
        accept    = (state == EMIT) && out_valid && out_ready;
        // first beat loads one cycle after capture; later beats load on the accept of the previous one
        load      = (state == EMIT) && (!out_valid || (out_ready && !out_last));
    end

    // ---------------- lane extraction ----------------
    always_comb begin
        load_lane = out_valid ? lane_q + 2'd1 : lane_q;
        lane_val  = '0;
        case (prec_q)
            2'b00: lane_val = {acc_q[55], acc_q};
            2'b01: lane_val = load_lane[0] ? {{29{acc_q[55]}}, acc_q[55:28]}
                                           : {{29{acc_q[27]}}, acc_q[27:0]};
            default: begin
                case (load_lane)
                    2'd0: lane_val = {{43{acc_q[13]}}, acc_q[13:0]};
                    2'd1: lane_val = {{43{acc_q[27]}}, acc_q[27:14]};
                    2'd2: lane_val = {{43{acc_q[41]}}, acc_q[41:28]};
                    default: lane_val = {{43{acc_q[55]}}, acc_q[55:42]};
                endcase
            end
        endcase

        case (prec_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
        beat_last = (load_lane == last_idx);
    end

    // ---------------- requantization ----------------
    always_comb begin
        rnd = '0;
        if (shamt_q != 6'd0) rnd = 57'sd1 <<< (shamt_q - 6'd1);
        // 57-bit lane keeps headroom so the rounding add never wraps
        sum     = lane_val + rnd;
        y_shift = sum >>> shamt_q;
        y_clip  = (relu_q && y_shift[56]) ? '0 : y_shift;

        beat_sat  = 1'b0;
        beat_data = y_clip[OUT_W-1:0];
        if (y_clip > SAT_MAX) begin
            beat_sat  = 1'b1;
            beat_data = SAT_MAX[OUT_W-1:0];
        end else if (y_clip < SAT_MIN) begin
            beat_sat  = 1'b1;
            beat_data = SAT_MIN[OUT_W-1:0];
        end
    end

    // ---------------- capture, beat registers, counters ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            prec_q    <= '0;
            shamt_q   <= '0;
            relu_q    <= 1'b0;
            lane_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
            prec_err  <= 1'b0;
            sat_count <= '0;
        end else begin
            prec_err <= 1'b0;

            if (capture) begin
                acc_q    <= acc_result;
                prec_q   <= prec;
                shamt_q  <= (shamt > 6'd55) ? 6'd55 : shamt;
                relu_q   <= relu_en;
                lane_q   <= '0;
                prec_err <= (prec == 2'b11);
            end

            if (accept && out_sat && sat_count != '1)
                sat_count <= sat_count + SATCNT_W'(1);

            if (load) begin
                out_valid <= 1'b1;
                lane_q    <= load_lane;
                out_lane  <= load_lane;
                out_data  <= beat_data;
                out_last  <= beat_last;
                out_sat   <= beat_sat;
            end else if (accept && out_last) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: reset, full/packed lanes, saturation/ReLU,
// backpressure, prec=11, shamt clamp and mid-emission reset.
module tb_mac_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_valid;
    logic        acc_ready;
    logic [55:0] acc_result;
    logic [1:0]  prec;
    logic [5:0]  shamt;
    logic        relu_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_lane;
    logic        out_last;
    logic        prec_err;
    logic [15:0] sat_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[4];

    mac_requant #(.OUT_W(8), .SATCNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_result(acc_result),
        .prec(prec), .shamt(shamt), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last),
        .prec_err(prec_err), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one capture; returns one cycle later, when lane 0 should be visible.
    task automatic capture(input logic [55:0] res, input logic [1:0] p,
                           input logic [5:0] s, input logic r, input string tag);
        acc_result = res;
        prec       = p;
        shamt      = s;
        relu_en    = r;
        acc_valid  = 1'b1;
        tick();
        acc_valid  = 1'b0;
        check_val({tag, "_valid_n"}, out_valid, 0);
        check_val({tag, "_busy"}, acc_ready, 0);
        tick();
    endtask

    // Checks n consecutive beats with out_ready held high.
    task automatic run_lanes(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s_v%0d", tag, i), out_valid, 1);
            check_val($sformatf("%s_d%0d", tag, i), longint'($signed(out_data)), exp_q[i]);
            check_val($sformatf("%s_l%0d", tag, i), out_lane, i);
            check_val($sformatf("%s_last%0d", tag, i), out_last, (i == n - 1) ? 1 : 0);
            check_val($sformatf("%s_rdy%0d", tag, i), acc_ready, 0);
            tick();
        end
        check_val({tag, "_done_rdy"}, acc_ready, 1);
        check_val({tag, "_done_v"}, out_valid, 0);
    endtask

    logic [55:0] pack4;
    int idx;

    initial begin
        rst        = 1'b1;
        acc_valid  = 1'b0;
        acc_result = '0;
        prec       = '0;
        shamt      = '0;
        relu_en    = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        check_val("rst_rdy", acc_ready, 1);
        check_val("rst_v", out_valid, 0);
        check_val("rst_sat", sat_count, 0);
        check_val("rst_data", out_data, 0);
        check_val("rst_lane", out_lane, 0);
        check_val("rst_last", out_last, 0);
        check_val("rst_err", prec_err, 0);
        rst = 1'b0;
        tick();

        // full precision: (180 + 2) >>> 2 = 45
        exp_q[0] = 45;
        capture(56'd180, 2'b00, 6'd2, 1'b0, "full");
        run_lanes(1, "full");
        check_val("full_sat", sat_count, 0);

        // four 14-bit lanes 7, -3, 100, -128 with shift 1 -> 4, -1, 50, -64
        pack4 = {14'h3F80, 14'h0064, 14'h3FFD, 14'h0007};
        exp_q[0] = 4; exp_q[1] = -1; exp_q[2] = 50; exp_q[3] = -64;
        capture(pack4, 2'b10, 6'd1, 1'b0, "p4");
        run_lanes(4, "p4");
        check_val("p4_sat", sat_count, 0);

        // two 28-bit lanes: 1000 saturates to 127, -1000 is ReLU-clipped (not counted)
        exp_q[0] = 127; exp_q[1] = 0;
        capture({28'hFFFFC18, 28'd1000}, 2'b01, 6'd0, 1'b1, "sat");
        run_lanes(2, "sat");
        check_val("sat_cnt", sat_count, 1);

        // backpressure on the same packed lanes, no shift: 7, -3, 100, -128
        exp_q[0] = 7; exp_q[1] = -3; exp_q[2] = 100; exp_q[3] = -128;
        out_ready = 1'b0;
        capture(pack4, 2'b10, 6'd0, 1'b0, "bp");
        for (int c = 0; c < 5; c++) begin
            check_val($sformatf("bp_stall_v%0d", c), out_valid, 1);
            check_val($sformatf("bp_stall_d%0d", c), longint'($signed(out_data)), exp_q[0]);
            check_val($sformatf("bp_stall_l%0d", c), out_lane, 0);
            check_val($sformatf("bp_stall_rdy%0d", c), acc_ready, 0);
            tick();
        end
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            out_ready = (c % 2 == 0);
            check_val($sformatf("bp_v%0d", c), out_valid, 1);
            check_val($sformatf("bp_d%0d", c), longint'($signed(out_data)), exp_q[idx]);
            check_val($sformatf("bp_l%0d", c), out_lane, idx);
            check_val($sformatf("bp_last%0d", c), out_last, (idx == 3) ? 1 : 0);
            check_val($sformatf("bp_rdy%0d", c), acc_ready, 0);
            tick();
            if (out_ready) idx++;
        end
        check_val("bp_count", idx, 4);
        check_val("bp_done_rdy", acc_ready, 1);
        check_val("bp_done_v", out_valid, 0);
        out_ready = 1'b1;
        check_val("bp_sat", sat_count, 1);

        // prec = 11: error pulse only
        acc_result = 56'd5;
        prec       = 2'b11;
        shamt      = 6'd0;
        acc_valid  = 1'b1;
        tick();
        acc_valid  = 1'b0;
        check_val("perr_pulse", prec_err, 1);
        check_val("perr_rdy", acc_ready, 1);
        check_val("perr_v", out_valid, 0);
        tick();
        check_val("perr_clear", prec_err, 0);
        check_val("perr_v2", out_valid, 0);

        // shamt 63 clamps to 55: (2^54 + 2^54) >>> 55 = 1
        exp_q[0] = 1;
        capture(56'h40_0000_0000_0000, 2'b00, 6'd63, 1'b0, "sh63");
        run_lanes(1, "sh63");

        // reset while lane 1 of a 4-lane emission is showing
        capture(pack4, 2'b10, 6'd0, 1'b0, "mrst");
        tick();
        check_val("mrst_lane1", out_lane, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mrst_v", out_valid, 0);
        check_val("mrst_rdy", acc_ready, 1);
        check_val("mrst_sat", sat_count, 0);
        tick();
        tick();
        check_val("mrst_v_after", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
